// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: arbitrates NUM_CH cache miss channels onto one line-wide
// RAM port. Each grant performs an optional dirty write-back followed by a
// refill. A RAM timeout aborts the access and reports it on ch_err.
//
// Handshake: a channel raises ch_req and holds it until it sees ch_done or
// ch_err. The arbiter holds ram_en, ram_we, ram_addr and ram_wdata stable
// until ram_resp, which is a one-cycle pulse that completes the access.
// ram_resp outside WB/RF is ignored.
module cache_mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wb,
    input  logic [NUM_CH*ADDR_W-1:0] ch_wb_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wb_line,
    input  logic [NUM_CH*ADDR_W-1:0] ch_rf_addr,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [LINE_W-1:0]        rf_line,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [LINE_W-1:0]        ram_wdata,
    input  logic                     ram_resp,
    input  logic [LINE_W-1:0]        ram_rdata,
    output logic                     busy
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RF   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [31:0]         timer_q, timer_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [LINE_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [LINE_W-1:0]   rf_line_q, rf_line_d;

    logic [NUM_CH-1:0]   req_eff;
    logic                any_req;
    logic [PTR_W-1:0]    pick;
    logic [31:0]         timer_inc;
    logic                timeout_hit;

    // Winner selection: first requester at/after the RR pointer, or lowest index.
    always_comb begin
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        pick    = '0;
        req_eff = ch_req & ~done_q & ~err_q;
        any_req = |req_eff;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (RR_EN != 0) ? int'(ptr_q) + i : i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req_eff[idx]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Access timer: counts WB/RF cycles without a RAM response.
    always_comb begin
        timer_inc   = timer_q + 32'd1;
        timeout_hit = (TIMEOUT > 0) && (timer_inc == 32'(TIMEOUT));
    end

    // Next-state and registered-output logic for the grant sequence.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = '0;
        win_d       = win_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        ram_en_d    = ram_en_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rf_addr_d   = rf_addr_q;
        rf_line_d   = rf_line_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    win_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ram_en_d      = 1'b1;
                    timer_d       = '0;
                    rf_addr_d     = ch_rf_addr[int'(pick)*ADDR_W +: ADDR_W];
                    if (ch_wb[pick]) begin
                        state_d     = S_WB;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = ch_wb_addr[int'(pick)*ADDR_W +: ADDR_W];
                        ram_wdata_d = ch_wb_line[int'(pick)*LINE_W +: LINE_W];
                    end else begin
                        state_d    = S_RF;
                        ram_we_d   = 1'b0;
                        ram_addr_d = ch_rf_addr[int'(pick)*ADDR_W +: ADDR_W];
                    end
                end
            end
            S_WB: begin
                if (ram_resp) begin
                    // Straight into the refill read; ram_en stays high.
                    state_d    = S_RF;
                    ram_we_d   = 1'b0;
                    ram_addr_d = rf_addr_q;
                    timer_d    = '0;
                end else if (timeout_hit) begin
                    state_d  = S_ERR;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    grant_d  = '0;
                    err_d    = grant_q;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_RF: begin
                if (ram_resp) begin
                    state_d   = S_DONE;
                    rf_line_d = ram_rdata;
                    ram_en_d  = 1'b0;
                    grant_d   = '0;
                    done_d    = grant_q;
                end else if (timeout_hit) begin
                    state_d  = S_ERR;
                    ram_en_d = 1'b0;
                    grant_d  = '0;
                    err_d    = grant_q;
                end else begin
                    timer_d = timer_inc;
                end
            end
            S_DONE, S_ERR: begin
                // Rotate priority past the channel just served.
                if (int'(win_q) == NUM_CH - 1) ptr_d = '0;
                else                           ptr_d = win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            win_q       <= '0;
            ptr_q       <= '0;
            timer_q     <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rf_addr_q   <= '0;
            rf_line_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rf_addr_q   <= rf_addr_d;
            rf_line_q   <= rf_line_d;
        end
    end

    assign ch_grant  = grant_q;
    assign ch_done   = done_q;
    assign ch_err    = err_q;
    assign rf_line   = rf_line_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Parametrised successor to the fixed two-cache memory glue: arbitrates NUM_CH cache miss channels (I-cache, D-cache, future L1 ports) onto one line-wide RAM port.
- Performs dirty write-back, then refill, per grant.
- Supports round-robin or fixed priority, and a per-access RAM timeout with error report.
- Sits between the cache arrays/controllers and the RAM model.

Parameters:
NUM_CH, 2, number of cache channels (1..8); channel 0 = I-cache, 1 = D-cache
ADDR_W, 32, address width
LINE_W, 256, cache line width in bits
RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
TIMEOUT, 0, max cycles waiting for ram_resp per access; 0 = disabled

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_req  in  NUM_CH  level miss request; held until ch_done/ch_err
ch_wb  in  NUM_CH  channel's victim line is dirty; write back before refill
ch_wb_addr  in  NUM_CH*ADDR_W  victim line address, slice i = channel i
ch_wb_line  in  NUM_CH*LINE_W  victim line data
ch_rf_addr  in  NUM_CH*ADDR_W  refill line address
ch_grant  out  NUM_CH  one-hot, high for whole grant
ch_done  out  NUM_CH  one-cycle pulse, refill data valid
ch_err  out  NUM_CH  one-cycle pulse, access aborted on timeout
rf_line  out  LINE_W  refill data, valid in ch_done cycle, held until next refill
ram_en  out  1  RAM access request
ram_we  out  1  1 = write, 0 = read
ram_addr  out  ADDR_W  RAM line address
ram_wdata  out  LINE_W  write data
ram_resp  in  1  one-cycle RAM completion pulse
ram_rdata  in  LINE_W  read data, valid with ram_resp
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer = 0, timer = 0. Reset mid-access aborts immediately; no done/err pulse is generated.
- States: IDLE, WB, RF, DONE, ERR.
- IDLE: if any ch_req, pick the winner in the same cycle:
  - RR_EN=1: first requester at or after the pointer, wrapping from NUM_CH-1 to 0.
  - RR_EN=0: lowest index.
- Next cycle after winner pick: ch_grant[w]=1, ram_en=1, and the channel's inputs are registered.
  - If ch_wb[w]: go to WB with ram_we=1, ram_addr=wb_addr, ram_wdata=wb_line.
  - Else: go to RF with ram_we=0, ram_addr=rf_addr.
- WB: hold outputs stable until ram_resp. Next cycle: RF with ram_en still 1, ram_we=0, ram_addr=rf_addr. No bubble.
- RF: hold until ram_resp. Same edge: latch ram_rdata into rf_line, drop ram_en. Next cycle is DONE.
- DONE: ch_done[w]=1 for 1 cycle; ch_grant drops; RR pointer = w+1 (mod NUM_CH); return to IDLE. A new grant is possible in the cycle after DONE, so minimum grant spacing is 1 idle cycle.
- Latency, no write-back, RAM responding N cycles after ram_en rises: ch_done = req + N + 2 cycles.
- Timer:
  - Clears on each ram_en rise and on each WB->RF transition.
  - Increments each WB/RF cycle without ram_resp.
  - If TIMEOUT>0 and timer reaches TIMEOUT: go to ERR. ERR drops ram_en, pulses ch_err[w] for 1 cycle, advances RR pointer as in DONE, returns to IDLE. rf_line is not updated.
- ram_resp in IDLE/DONE/ERR: ignored.
- Request handling:
  - ch_req deasserted mid-grant: access still completes; pulse still issued.
  - Other channels' requests during a grant wait; they are never dropped.
  - Request seen by the arbiter = ch_req & ~ch_done & ~ch_err, so the granted channel is not re-granted while it lowers ch_req.
- Registered wb/rf inputs are captured once at grant; later input changes are ignored.
- Invariant: ch_grant is one-hot or zero; ram_we=1 only in WB.

Test Plan:
- Single refill: NUM_CH=2, ch_req=01, rf_addr=0x100, RAM resp 3 cycles after ram_en, rdata=0xA5..A5 -> ram_we=0, ram_addr=0x100, ch_done=01 at req+5, rf_line=0xA5..A5.
- Write-back then refill: ch_req=10, ch_wb=10, wb_addr=0x2000, rf_addr=0x3000 -> write to 0x2000 with wb_line, then read from 0x3000 with no ram_en gap, single ch_done=10.
- Round-robin fairness: NUM_CH=4, all requesting continuously -> grant order 0,1,2,3,0; with RR_EN=0 -> channel 0 re-granted every time.
- Timeout: TIMEOUT=8, RAM never responds -> ram_en high 8 cycles, then dropped, ch_err pulse on granted channel, rf_line unchanged, next requester granted.
- Reset mid-WB: assert rst during WB -> next cycle all outputs 0; stray ram_resp afterwards produces no ch_done.
- Simultaneous request and late ram_resp: ch_req for ch1 rising in the DONE cycle of ch0 plus ram_resp pulse in IDLE -> resp ignored, ch1 granted one cycle later.
